fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Control FSM that sequences the 8-bit program counter / fetch stage.
//  Drives the PC's reset, hold and branch-take controls. Implements the start/done program handshake.
//  Stretches multi-cycle memory instructions and resolves blt/bne branch decisions from ALU flags.
//  Stops on halt, on end of instruction memory, or on watchdog timeout. Sits between decode/ALU and the PC.
// PARAMETERS
//  MEM_LAT     2       extra hold cycles for a load/store (0 = single-cycle memory, is_mem ignored)
//  MAX_CYCLES  16'hFFFF watchdog limit on counted cycles; reaching it forces DONE with timeout=1
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high; forces IDLE
//  start        in   1   begin/restart program (sampled in IDLE and DONE only)
//  is_halt      in   1   current instruction is halt
//  is_mem       in   1   current instruction is load/store
//  branch_sig   in   1   current instruction is a branch
//  branch_type  in   1   0 = blt, 1 = bne
//  cmp_lt       in   1   ALU flag: compare result less-than
//  cmp_ne       in   1   ALU flag: compare result not-equal
//  pc           in   8   current PC value
//  pc_reset     out  1   drives PC synchronous reset to 0
//  pc_hold      out  1   drives PC halt (PC keeps value)
//  take_branch  out  1   PC adds branch offset this edge
//  mem_en       out  1   data memory access active
//  done         out  1   program finished (level)
//  timeout      out  1   finish caused by watchdog (valid while done=1)
//  cycle_count  out  16  cycles spent in RUN+STALL for the last/current program
// BEHAVIOUR
//  States: IDLE, INIT, RUN, STALL, DONE.
//  Async reset: state=IDLE, wcnt=0, done=0, timeout=0, cycle_count=0.
//    Comb outputs in IDLE: pc_reset=1, pc_hold=1, take_branch=0, mem_en=0.
//  done, timeout, cycle_count are registered; pc_reset, pc_hold, take_branch, mem_en are combinational from state+inputs.
//  IDLE: start=1 -> INIT.
//  INIT (exactly 1 cycle): pc_reset=1, pc_hold=1.
//    Clears cycle_count, done, timeout -> RUN.
//  RUN: cycle_count += 1 per cycle (saturates at 16'hFFFF). Priority, highest first:
//    1. watchdog: cycle_count==MAX_CYCLES-1 -> pc_hold=1, next DONE, timeout<=1.
//    2. is_halt -> pc_hold=1, next DONE (halt instruction does not advance PC).
//    3. is_mem && MEM_LAT>0 -> pc_hold=1, mem_en=1, wcnt<=MEM_LAT-1, next STALL.
//    4. pc==8'hFF -> pc_hold=1, next DONE.
//       Applies after any mem stall; no wrap to 0 is ever taken.
//       A branch at 0xFF is still resolved and taken if its condition holds.
//    5. otherwise pc_hold=0.
//       take_branch = branch_sig & (branch_type ? cmp_ne : cmp_lt).
//       Else PC increments.
//    is_mem with MEM_LAT=0: no stall; mem_en=1 for that one cycle only.
//  STALL: pc_hold=1 while wcnt!=0; mem_en=1; wcnt -= 1; cycle_count += 1; watchdog checked as in RUN.
//    At wcnt==0: pc_hold=0, next RUN; PC advances on this edge, or DONE at pc==8'hFF.
//    A mem instruction therefore occupies MEM_LAT+1 cycles.
//    take_branch is always 0 in STALL and in every hold cycle.
//  DONE: pc_hold=1, done=1; cycle_count and timeout frozen; start=1 -> INIT (restart).
//  start in RUN/STALL is ignored. Reset mid-operation aborts immediately to IDLE; no handshake is owed.
// TESTING
//  1. Reset -> start pulse: INIT 1 cycle (pc_reset=1), RUN next cycle with pc_reset=0, pc_hold=0; cycle_count counts from 1.
//  2. blt with cmp_lt=1 -> take_branch=1; bne with cmp_ne=0 -> take_branch=0.
//     branch_sig=0 with flags set -> take_branch=0.
//  3. MEM_LAT=2, is_mem at pc=5: pc_hold=1 and mem_en=1 for 2 cycles, advance on 3rd; PC reaches 6 after 3 cycles.
//  4. is_halt at pc=10 after 10 RUN cycles: done=1 next cycle, timeout=0, cycle_count=11, PC stays 10.
//     start -> INIT, counters cleared.
//  5. MAX_CYCLES=20, infinite loop: done=1, timeout=1, cycle_count=20.
//     pc=8'hFF non-branch: done=1, PC stays FF.
//  6. Assert reset while in STALL: all outputs return to reset values asynchronously; no DONE is entered.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Control FSM for the 8-bit PC / fetch stage: start/done handshake, memory stalls,
// blt/bne branch resolution, and halt / end-of-memory / watchdog termination.
module fetch_sequencer #(
   parameter int          MEM_LAT    = 2,
   parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_halt,
   input  logic        is_mem,
   input  logic        branch_sig,
   input  logic        branch_type,
   input  logic        cmp_lt,
   input  logic        cmp_ne,
   input  logic [7:0]  pc,
   output logic        pc_reset,
   output logic        pc_hold,
   output logic        take_branch,
   output logic        mem_en,
   output logic        done,
   output logic        timeout,
   output logic [15:0] cycle_count
);

   localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      RUN,
      STALL,
      FINISHED
   } state_t;

   state_t              state;
   logic [WCNT_W-1:0]   wcnt;

   logic branch_taken;
   logic watchdog;
   logic go_done;
   logic go_stall;

   assign branch_taken = branch_sig & (branch_type ? cmp_ne : cmp_lt);
   assign watchdog     = (cycle_count == MAX_CYCLES - 16'd1);

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      pc_reset    = 1'b0;
      pc_hold     = 1'b1;
      take_branch = 1'b0;
      mem_en      = 1'b0;
      go_done     = 1'b0;
      go_stall    = 1'b0;
      case (state)
         IDLE, INIT: pc_reset = 1'b1;
         RUN: begin
            if (watchdog || is_halt) begin
               go_done = 1'b1;
            end else if (is_mem && (MEM_LAT > 0)) begin
               mem_en   = 1'b1;
               go_stall = 1'b1;
            end else begin
               mem_en = is_mem;
               // A taken branch at the last address is the only way past 0xFF.
               if (pc == 8'hFF && !branch_taken) begin
                  go_done = 1'b1;
               end else begin
                  pc_hold     = 1'b0;
                  take_branch = branch_taken;
               end
            end
         end
         STALL: begin
            mem_en = 1'b1;
            if (watchdog) begin
               go_done = 1'b1;
            end else if (wcnt == '0) begin
               if (pc == 8'hFF) go_done = 1'b1;
               else             pc_hold = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wcnt        <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= 16'd0;
      end else begin
         case (state)
            IDLE: if (start) state <= INIT;
            INIT: begin
               cycle_count <= 16'd0;
               done        <= 1'b0;
               timeout     <= 1'b0;
               state       <= RUN;
            end
            RUN, STALL: begin
               if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
               if (go_done) begin
                  state   <= FINISHED;
                  done    <= 1'b1;
                  timeout <= watchdog;
               end else if (go_stall) begin
                  state <= STALL;
                  wcnt  <= WCNT_W'(MEM_LAT - 1);
               end else if (state == STALL) begin
                  if (wcnt != '0) wcnt  <= wcnt - 1'b1;
                  else            state <= RUN;
               end
            end
            FINISHED: if (start) state <= INIT;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle-by-cycle vector table plus hand-written
// watchdog and reset-during-stall sequences.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, is_halt, is_mem, branch_sig, branch_type, cmp_lt, cmp_ne;
   logic [7:0]  pc;
   logic        pc_reset, pc_hold, take_branch, mem_en, done, timeout;
   logic [15:0] cycle_count;

   int total = 0;
   int bad   = 0;

   fetch_sequencer #(.MEM_LAT(2), .MAX_CYCLES(16'd20)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .is_halt     (is_halt),
      .is_mem      (is_mem),
      .branch_sig  (branch_sig),
      .branch_type (branch_type),
      .cmp_lt      (cmp_lt),
      .cmp_ne      (cmp_ne),
      .pc          (pc),
      .pc_reset    (pc_reset),
      .pc_hold     (pc_hold),
      .take_branch (take_branch),
      .mem_en      (mem_en),
      .done        (done),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start, halt, mem, br, bt, lt, ne;
      logic [7:0] pc;
      logic       prst, hold, tk, men, dn, to;
      logic [15:0] cc;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, h, m, b, bt, lt, ne, input logic [7:0] p,
                      input logic prst, hold, tk, men, dn, to, input logic [15:0] cc);
      vq.push_back('{st, h, m, b, bt, lt, ne, p, prst, hold, tk, men, dn, to, cc});
   endtask

   task automatic drive(input logic st, h, m, b, bt, lt, ne, input logic [7:0] p);
      start = st; is_halt = h; is_mem = m; branch_sig = b;
      branch_type = bt; cmp_lt = lt; cmp_ne = ne; pc = p;
   endtask

   task automatic check_all(input string tag, input logic prst, hold, tk, men, dn, to,
                            input logic [15:0] cc);
      check({tag, ".pc_reset"},    16'(pc_reset),    16'(prst));
      check({tag, ".pc_hold"},     16'(pc_hold),     16'(hold));
      check({tag, ".take_branch"}, 16'(take_branch), 16'(tk));
      check({tag, ".mem_en"},      16'(mem_en),      16'(men));
      check({tag, ".done"},        16'(done),        16'(dn));
      check({tag, ".timeout"},     16'(timeout),     16'(to));
      check({tag, ".cycle_count"}, cycle_count,      cc);
   endtask

   int n;

   initial begin
      //   st h m b bt lt ne pc      | prst hold tk men dn to cc
      add(1, 0,0,0,0, 0, 0, 8'h00,    1,   1,  0, 0,  0, 0, 16'd0);  // IDLE, start
      add(0, 0,0,0,0, 0, 0, 8'h00,    1,   1,  0, 0,  0, 0, 16'd0);  // INIT
      add(0, 0,0,0,0, 0, 0, 8'h00,    0,   0,  0, 0,  0, 0, 16'd0);  // RUN plain
      add(0, 0,0,1,0, 1, 0, 8'h01,    0,   0,  1, 0,  0, 0, 16'd1);  // blt taken
      add(0, 0,0,1,1, 1, 0, 8'h03,    0,   0,  0, 0,  0, 0, 16'd2);  // bne not taken
      add(0, 0,0,0,1, 1, 1, 8'h04,    0,   0,  0, 0,  0, 0, 16'd3);  // no branch, flags set
      add(0, 0,1,0,0, 0, 0, 8'h05,    0,   1,  0, 1,  0, 0, 16'd4);  // mem issue
      add(1, 0,1,0,0, 0, 0, 8'h05,    0,   1,  0, 1,  0, 0, 16'd5);  // STALL, start ignored
      add(0, 0,1,1,0, 1, 0, 8'h05,    0,   0,  0, 1,  0, 0, 16'd6);  // STALL release, no branch
      add(0, 0,0,1,1, 0, 1, 8'h06,    0,   0,  1, 0,  0, 0, 16'd7);  // bne taken
      add(0, 0,0,0,0, 0, 0, 8'h09,    0,   0,  0, 0,  0, 0, 16'd8);
      add(0, 1,1,1,0, 1, 0, 8'h0A,    0,   1,  0, 0,  0, 0, 16'd9);  // halt beats mem/branch
      add(0, 0,0,0,0, 0, 0, 8'h0A,    0,   1,  0, 0,  1, 0, 16'd10); // DONE
      add(0, 0,0,1,0, 1, 0, 8'h0A,    0,   1,  0, 0,  1, 0, 16'd10); // DONE frozen
      add(1, 0,0,0,0, 0, 0, 8'h0A,    0,   1,  0, 0,  1, 0, 16'd10); // restart
      add(0, 0,0,0,0, 0, 0, 8'h00,    1,   1,  0, 0,  1, 0, 16'd10); // INIT
      add(1, 0,0,0,0, 0, 0, 8'h00,    0,   0,  0, 0,  0, 0, 16'd0);  // RUN, start ignored
      add(0, 0,0,0,0, 0, 0, 8'hFF,    0,   1,  0, 0,  0, 0, 16'd1);  // end of memory
      add(1, 0,0,0,0, 0, 0, 8'hFF,    0,   1,  0, 0,  1, 0, 16'd2);  // DONE, restart
      add(0, 0,0,0,0, 0, 0, 8'h00,    1,   1,  0, 0,  1, 0, 16'd2);  // INIT
      add(0, 0,0,1,0, 1, 0, 8'hFF,    0,   0,  1, 0,  0, 0, 16'd0);  // branch at FF taken
      add(0, 0,1,0,0, 0, 0, 8'hFF,    0,   1,  0, 1,  0, 0, 16'd1);  // mem at FF
      add(0, 0,1,0,0, 0, 0, 8'hFF,    0,   1,  0, 1,  0, 0, 16'd2);
      add(0, 0,1,0,0, 0, 0, 8'hFF,    0,   1,  0, 1,  0, 0, 16'd3);  // stall end at FF
      add(0, 0,0,0,0, 0, 0, 8'hFF,    0,   1,  0, 0,  1, 0, 16'd4);  // DONE

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
      repeat (2) @(negedge clk);
      check_all("reset", 1, 1, 0, 0, 0, 0, 16'd0);
      reset = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].start, vq[i].halt, vq[i].mem, vq[i].br, vq[i].bt, vq[i].lt, vq[i].ne, vq[i].pc);
         #1;
         check_all($sformatf("v%0d", i), vq[i].prst, vq[i].hold, vq[i].tk, vq[i].men,
                   vq[i].dn, vq[i].to, vq[i].cc);
         @(negedge clk);
      end

      // Watchdog: infinite blt loop at pc 3 must stop after 20 counted cycles.
      drive(1, 0, 0, 0, 0, 0, 0, 8'h03);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 1, 0, 8'h03);
      #1;
      check("wd.init_pc_reset", 16'(pc_reset), 16'd1);
      @(negedge clk);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (done) break;
         if (n == 19) begin
            check("wd.last_hold", 16'(pc_hold), 16'd1);
            check("wd.last_take", 16'(take_branch), 16'd0);
            check("wd.last_cc", cycle_count, 16'd19);
         end
         n++;
         @(negedge clk);
      end
      check("wd.done", 16'(done), 16'd1);
      check("wd.timeout", 16'(timeout), 16'd1);
      check("wd.cycle_count", cycle_count, 16'd20);
      check("wd.run_cycles", 16'(n), 16'd20);

      // Restart clears timeout, then reset is asserted mid-STALL.
      drive(1, 0, 0, 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
      #1;
      check("rs.init_timeout_held", 16'(timeout), 16'd1);
      @(negedge clk);
      #1;
      check_all("rs.run", 0, 0, 0, 0, 0, 0, 16'd0);
      drive(0, 0, 1, 0, 0, 0, 0, 8'h05);
      @(negedge clk);
      #1;
      check("rs.stall_hold", 16'(pc_hold), 16'd1);
      check("rs.stall_mem", 16'(mem_en), 16'd1);
      check("rs.stall_cc", cycle_count, 16'd1);
      #2 reset = 1'b1;
      #1;
      check_all("rs.async", 1, 1, 0, 0, 0, 0, 16'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_all("rs.idle", 1, 1, 0, 0, 0, 0, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
